sigma_sched_4ch: RTL and testbench



---
 rtl/sigma_sched_4ch.sv | 136 +++++++++++++
 tb/tb_sigma_sched_4ch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_sched_4ch.sv
// Four-channel sigma accumulator scheduler: arbiter, sign-magnitude conversion, per-channel NPTS-point sums.
// Build option: define SIGMA_SCHED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module sigma_sched_4ch #(
    parameter int NPTS  = 16,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             res,
    input  logic [3:0]       req,
    input  logic [31:0]      data_in,
    output logic [3:0]       gnt,
    output logic [OUT_W-1:0] data_out,
    output logic [1:0]       ch_out,
    output logic             syn_out
);

    localparam int CNT_W = $clog2(NPTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPTS - 1);

    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gidx;
    logic             gvalid;
    logic [7:0]       sample;
    logic [OUT_W-1:0] mag_ext;
    logic [OUT_W-1:0] conv;

    logic [OUT_W-1:0] d1_q, d1_d;
    logic [1:0]       c1_q, c1_d;
    logic             v1_q, v1_d;

    logic [OUT_W-1:0] acc_q [4];
    logic [OUT_W-1:0] acc_d [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [OUT_W-1:0] sum;

    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic [1:0]       ch_out_q, ch_out_d;
    logic             syn_q, syn_d;

    // Arbiter: descending scan so the first candidate in search order is the one left standing.
    always_comb begin
        logic [1:0] idx;
        gidx   = 2'd0;
        gvalid = 1'b0;
        idx    = 2'd0;
`ifdef SIGMA_SCHED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            idx = 2'(k);
            if (req[idx]) begin
                gidx   = idx;
                gvalid = 1'b1;
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                gidx   = idx;
                gvalid = 1'b1;
            end
        end
`endif
        if (res) begin
            gvalid = 1'b0;
        end
        gnt   = gvalid ? (4'b0001 << gidx) : 4'b0000;
        ptr_d = gvalid ? (gidx + 2'd1) : ptr_q;
    end

    // Sign-magnitude to two's complement; 0x80 naturally maps to zero.
    always_comb begin
        sample  = data_in[{gidx, 3'b000} +: 8];
        mag_ext = {{(OUT_W-7){1'b0}}, sample[6:0]};
        conv    = sample[7] ? (~mag_ext + 1'b1) : mag_ext;
        d1_d    = conv;
        c1_d    = gidx;
        v1_d    = gvalid;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = cnt_q[i];
        end
        data_out_d = data_out_q;
        ch_out_d   = ch_out_q;
        syn_d      = 1'b0;
        sum        = acc_q[c1_q] + d1_q;
        if (v1_q) begin
            if (cnt_q[c1_q] != CNT_LAST) begin
                acc_d[c1_q] = sum;
                cnt_d[c1_q] = cnt_q[c1_q] + 1'b1;
            end else begin
                data_out_d  = sum;
                ch_out_d    = c1_q;
                syn_d       = 1'b1;
                acc_d[c1_q] = '0;
                cnt_d[c1_q] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            ptr_q      <= 2'd0;
            d1_q       <= '0;
            c1_q       <= 2'd0;
            v1_q       <= 1'b0;
            data_out_q <= '0;
            ch_out_q   <= 2'd0;
            syn_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            d1_q       <= d1_d;
            c1_q       <= c1_d;
            v1_q       <= v1_d;
            data_out_q <= data_out_d;
            ch_out_q   <= ch_out_d;
            syn_q      <= syn_d;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign data_out = data_out_q;
    assign ch_out   = ch_out_q;
    assign syn_out  = syn_q;

endmodule

// File: tb/tb_sigma_sched_4ch.sv
// Directed self-checking bench for sigma_sched_4ch (default 16-point, 12-bit build).
module tb_sigma_sched_4ch;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [3:0]  req = 4'hF;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  gnt;
    logic [11:0] data_out;
    logic [1:0]  ch_out;
    logic        syn_out;

    int tests = 0;
    int fails = 0;

    int          syn_cnt = 0;
    logic [11:0] syn_data [64];
    logic [1:0]  syn_ch [64];

    sigma_sched_4ch #(.NPTS(16), .OUT_W(12)) dut (
        .clk      (clk),
        .res      (res),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .data_out (data_out),
        .ch_out   (ch_out),
        .syn_out  (syn_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (syn_out) begin
            syn_data[syn_cnt % 64] <= data_out;
            syn_ch[syn_cnt % 64]   <= ch_out;
            syn_cnt                <= syn_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic r, input logic [3:0] rq, input logic [31:0] d,
                        output logic [3:0] g);
        @(posedge clk);
        #2;
        res     = r;
        req     = rq;
        data_in = d;
        #1;
        g = gnt;
    endtask

    task automatic idle(input int n);
        logic [3:0] g;
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 32'h0, g);
    endtask

    task automatic do_reset();
        logic [3:0] g;
        tick(1'b1, 4'h0, 32'h0, g);
        tick(1'b0, 4'h0, 32'h0, g);
    endtask

    task automatic run_n(input logic [3:0] rq, input logic [31:0] d, input int n, output int ng);
        logic [3:0] g;
        ng = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b0, rq, d, g);
            if (g === rq) ng++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] g;
        tick(1'b1, 4'hF, 32'h01010101, g);
        tests++;
        if (g !== 4'b0000) begin
            fails++;
            $display("FAIL reset_gnt: gnt=%b required 0000", g);
        end
        tick(1'b1, 4'hF, 32'h01010101, g);
        tick(1'b0, 4'h0, 32'h0, g);
        tests++;
        if (data_out !== 12'h000 || ch_out !== 2'd0 || syn_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: data_out=%h ch_out=%0d syn_out=%b required 000/0/0",
                     data_out, ch_out, syn_out);
        end
        tick(1'b0, 4'hF, 32'h0, g);
        tests++;
        if (g !== 4'b0001) begin
            fails++;
            $display("FAIL reset_ptr: first gnt=%b required 0001", g);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        logic [3:0] g;
        int base;
        int ng;
        do_reset();
        base = syn_cnt;
        run_n(4'b0001, 32'h00000001, 16, ng);
        tests++;
        if (ng !== 16) begin
            fails++;
            $display("FAIL single_gnt: grants=%0d required 16", ng);
        end
        tick(1'b0, 4'h0, 32'h0, g);
        tests++;
        if (syn_out !== 1'b0) begin
            fails++;
            $display("FAIL single_early: syn_out=%b at T+1 required 0", syn_out);
        end
        tick(1'b0, 4'h0, 32'h0, g);
        tests++;
        if (syn_out !== 1'b1 || data_out !== 12'h010 || ch_out !== 2'd0) begin
            fails++;
            $display("FAIL single_result: syn=%b data=%h ch=%0d required 1/010/0",
                     syn_out, data_out, ch_out);
        end
        tick(1'b0, 4'h0, 32'h0, g);
        tests++;
        if (syn_out !== 1'b0 || data_out !== 12'h010 || (syn_cnt - base) !== 1) begin
            fails++;
            $display("FAIL single_pulse: syn=%b data=%h syncs=%0d required 0/010/1",
                     syn_out, data_out, syn_cnt - base);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_negative();
        int base;
        int ng;
        do_reset();
        base = syn_cnt;
        run_n(4'b0100, 32'h00FF0000, 16, ng);
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 1 || syn_data[base % 64] !== 12'h810 || syn_ch[base % 64] !== 2'd2) begin
            fails++;
            $display("FAIL neg_full: syncs=%0d data=%h ch=%0d required 1/810/2",
                     syn_cnt - base, syn_data[base % 64], syn_ch[base % 64]);
        end
        run_n(4'b0100, 32'h00800000, 16, ng);
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 2 || syn_data[(base + 1) % 64] !== 12'h000 || syn_ch[(base + 1) % 64] !== 2'd2) begin
            fails++;
            $display("FAIL neg_zero: syncs=%0d data=%h ch=%0d required 2/000/2",
                     syn_cnt - base, syn_data[(base + 1) % 64], syn_ch[(base + 1) % 64]);
        end
        $display("[TB] test_negative done");
    endtask

    task automatic test_fairness();
        logic [3:0] g;
        logic [3:0] exp_g;
        logic [1:0] exp_ch;
        int base;
        do_reset();
        base = syn_cnt;
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 4'hF, 32'h01010101, g);
`ifdef SIGMA_SCHED_PRIO_EN
            exp_g = 4'b0001;
`else
            exp_g = 4'b0001 << (i % 4);
`endif
            tests++;
            if (g !== exp_g) begin
                fails++;
                $display("FAIL fair_gnt[%0d]: gnt=%b required %b", i, g, exp_g);
            end
        end
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 4) begin
            fails++;
            $display("FAIL fair_count: syncs=%0d required 4", syn_cnt - base);
        end
        for (int k = 0; k < 4; k++) begin
`ifdef SIGMA_SCHED_PRIO_EN
            exp_ch = 2'd0;
`else
            exp_ch = 2'(k);
`endif
            tests++;
            if (syn_ch[(base + k) % 64] !== exp_ch || syn_data[(base + k) % 64] !== 12'h010) begin
                fails++;
                $display("FAIL fair_result[%0d]: ch=%0d data=%h required %0d/010",
                         k, syn_ch[(base + k) % 64], syn_data[(base + k) % 64], exp_ch);
            end
        end
        $display("[TB] test_fairness done");
    endtask

    task automatic test_interleave();
        logic [3:0] g;
        logic [3:0] rq;
        logic [7:0] b1;
        int base;
        int n1;
        int n3;
        do_reset();
        base = syn_cnt;
        n1 = 0;
        n3 = 0;
        for (int c = 0; c < 100 && (n1 < 16 || n3 < 16); c++) begin
            rq = {n3 < 16, 1'b0, n1 < 16, 1'b0};
            b1 = n1[0] ? 8'h85 : 8'h05;
            tick(1'b0, rq, {8'h7F, 8'h00, b1, 8'h00}, g);
            if (g[1]) n1++;
            if (g[3]) n3++;
        end
        tests++;
        if (n1 !== 16 || n3 !== 16) begin
            fails++;
            $display("FAIL inter_grants: ch1=%0d ch3=%0d required 16/16 within 100 cycles", n1, n3);
        end
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 2 || syn_ch[base % 64] !== 2'd1 || syn_data[base % 64] !== 12'h000) begin
            fails++;
            $display("FAIL inter_ch1: syncs=%0d ch=%0d data=%h required 2/1/000",
                     syn_cnt - base, syn_ch[base % 64], syn_data[base % 64]);
        end
        tests++;
        if (syn_ch[(base + 1) % 64] !== 2'd3 || syn_data[(base + 1) % 64] !== 12'h7F0) begin
            fails++;
            $display("FAIL inter_ch3: ch=%0d data=%h required 3/7f0",
                     syn_ch[(base + 1) % 64], syn_data[(base + 1) % 64]);
        end
        $display("[TB] test_interleave done");
    endtask

    task automatic test_reset_mid();
        int base;
        int ng;
        do_reset();
        base = syn_cnt;
        run_n(4'b0001, 32'h00000001, 10, ng);
        do_reset();
        run_n(4'b0001, 32'h00000002, 16, ng);
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 1 || syn_data[base % 64] !== 12'h020 || syn_ch[base % 64] !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid: syncs=%0d data=%h ch=%0d required 1/020/0",
                     syn_cnt - base, syn_data[base % 64], syn_ch[base % 64]);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_handshake();
        logic [3:0] g;
        int base;
        int ng;
        do_reset();
        base = syn_cnt;
        tick(1'b0, 4'b0001, 32'h00000000, g);
        tests++;
        if (g !== 4'b0001) begin
            fails++;
            $display("FAIL hs_first: gnt=%b required 0001", g);
        end
        tick(1'b0, 4'b0011, 32'h00004000, g);
        tests++;
        if (g !== 4'b0010) begin
            fails++;
            $display("FAIL hs_ch1_grant: gnt=%b required 0010", g);
        end
        tick(1'b0, 4'b0011, 32'h00007F00, g);
        tests++;
        if (g !== 4'b0001) begin
            fails++;
            $display("FAIL hs_ch0_turn: gnt=%b required 0001", g);
        end
        tick(1'b0, 4'b0011, 32'h00000200, g);
        tests++;
        if (g !== 4'b0010) begin
            fails++;
            $display("FAIL hs_ch1_again: gnt=%b required 0010", g);
        end
        run_n(4'b0010, 32'h00000100, 14, ng);
        idle(3);
        tests++;
        if ((syn_cnt - base) !== 1 || syn_data[base % 64] !== 12'h050 || syn_ch[base % 64] !== 2'd1) begin
            fails++;
            $display("FAIL hs_result: syncs=%0d data=%h ch=%0d required 1/050/1",
                     syn_cnt - base, syn_data[base % 64], syn_ch[base % 64]);
        end
        $display("[TB] test_handshake done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_fairness();
        test_interleave();
        test_reset_mid();
        test_handshake();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
